// File: rtl/bram_mem_responder.sv
// Stand-in for the PSRAM memCtrl client port, backed by on-chip RAM for bring-up.
// Handles one transaction at a time with fixed write/read latencies and a busy window after reset.
module bram_mem_responder #(
  parameter int ADDR_BITS   = 10,
  parameter int WR_LAT      = 4,
  parameter int RD_LAT      = 6,
  parameter int INIT_CYCLES = 16
) (
  input  logic        clkSys,
  input  logic        rst,
  input  logic        i_cs,
  input  logic        i_write,
  input  logic [23:0] i_address,
  input  logic        i_bank,
  input  logic [7:0]  i_dataToWrite,
  output logic [7:0]  o_dataRead,
  output logic        o_busy,
  output logic        o_dataReady,
  output logic [3:0]  o_state
);
  // state | meaning
  // IDLE  | accepting requests, busy low
  // INIT  | post-reset busy window, counting down INIT_CYCLES
  // WRITE | write in flight, byte stored on terminal count
  // READ  | read in flight, result registered on terminal count
  typedef enum logic [3:0] {
    IDLE  = 4'd0,
    INIT  = 4'd1,
    WRITE = 4'd2,
    READ  = 4'd3
  } state_t;

  localparam int DEPTH   = 2 ** (ADDR_BITS + 1);
  localparam int LAT_MAX = (WR_LAT > RD_LAT) ? WR_LAT : RD_LAT;
  localparam int CNT_MAX = (INIT_CYCLES > LAT_MAX) ? INIT_CYCLES : LAT_MAX;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  state_t             state, state_nx;
  logic [CNT_W-1:0]   cnt, cnt_nx;
  logic [ADDR_BITS:0] idx, idx_nx;
  logic [7:0]         wdata, wdata_nx;
  logic [7:0]         rdata_nx;
  logic               busy_nx, ready_nx;
  logic               mem_we;
  logic               last_tick;
  logic [7:0]         mem [DEPTH];

  // Upper address bits are deliberately ignored so addresses alias per bank.
  logic unused_addr;
  assign unused_addr = ^i_address[23:ADDR_BITS];

  assign last_tick = (cnt == CNT_W'(1));
  assign o_state   = state;

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    idx_nx   = idx;
    wdata_nx = wdata;
    rdata_nx = o_dataRead;
    busy_nx  = o_busy;
    ready_nx = o_dataReady;
    mem_we   = 1'b0;
    case (state)
      INIT: begin
        if (last_tick) begin
          state_nx = IDLE;
          busy_nx  = 1'b0;
        end else begin
          cnt_nx = cnt - CNT_W'(1);
        end
      end
      IDLE: begin
        if (!i_cs) begin
          idx_nx   = {i_bank, i_address[ADDR_BITS-1:0]};
          wdata_nx = i_dataToWrite;
          busy_nx  = 1'b1;
          ready_nx = 1'b0;
          state_nx = i_write ? WRITE : READ;
          cnt_nx   = i_write ? CNT_W'(WR_LAT) : CNT_W'(RD_LAT);
        end
      end
      WRITE: begin
        if (last_tick) begin
          mem_we   = 1'b1;
          state_nx = IDLE;
          busy_nx  = 1'b0;
        end else begin
          cnt_nx = cnt - CNT_W'(1);
        end
      end
      READ: begin
        if (last_tick) begin
          rdata_nx = mem[idx];
          ready_nx = 1'b1;
          state_nx = IDLE;
          busy_nx  = 1'b0;
        end else begin
          cnt_nx = cnt - CNT_W'(1);
        end
      end
      default: begin
        state_nx = IDLE;
        busy_nx  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clkSys or negedge rst) begin
    if (!rst) begin
      state       <= INIT;
      cnt         <= CNT_W'(INIT_CYCLES);
      idx         <= '0;
      wdata       <= '0;
      o_dataRead  <= 8'h00;
      o_busy      <= 1'b1;
      o_dataReady <= 1'b0;
    end else begin
      state       <= state_nx;
      cnt         <= cnt_nx;
      idx         <= idx_nx;
      wdata       <= wdata_nx;
      o_dataRead  <= rdata_nx;
      o_busy      <= busy_nx;
      o_dataReady <= ready_nx;
    end
  end

  // Memory has no reset so its contents survive a reset of the control logic.
  always_ff @(posedge clkSys) begin
    if (mem_we) mem[idx] <= wdata;
  end

endmodule

// File: tb/tb_bram_mem_responder.sv
// Bench for bram_mem_responder: directed scenarios plus randomized traffic against a
// timestamp-based transaction model of the responder.
module tb_bram_mem_responder;
  localparam int AB = 10;
  localparam int WL = 4;
  localparam int RL = 6;
  localparam int IC = 16;

  logic        clkSys = 1'b0;
  logic        rst = 1'b0;
  logic        i_cs = 1'b1;
  logic        i_write = 1'b0;
  logic [23:0] i_address = '0;
  logic        i_bank = 1'b0;
  logic [7:0]  i_dataToWrite = '0;
  logic [7:0]  o_dataRead;
  logic        o_busy;
  logic        o_dataReady;
  logic [3:0]  o_state;

  int total = 0;
  int bad = 0;

  bram_mem_responder #(
    .ADDR_BITS(AB), .WR_LAT(WL), .RD_LAT(RL), .INIT_CYCLES(IC)
  ) dut (
    .clkSys(clkSys), .rst(rst), .i_cs(i_cs), .i_write(i_write),
    .i_address(i_address), .i_bank(i_bank), .i_dataToWrite(i_dataToWrite),
    .o_dataRead(o_dataRead), .o_busy(o_busy), .o_dataReady(o_dataReady),
    .o_state(o_state)
  );

  always #5 clkSys = ~clkSys;

  // Transaction model: an activity (init/write/read) occupies the responder until done_edge.
  int  mem_m   [0:2047];
  bit  known_m [0:2047];
  int  e = 0;
  int  done_edge = 0;
  int  kind = 1;
  int  p_idx = 0;
  int  p_data = 0;
  int  m_rdata = 0;
  bit  m_ready = 1'b0;
  bit  m_rknown = 1'b1;
  bit  chk_on = 1'b0;
  int  exp_busy;

  always @(posedge clkSys) begin
    e++;
    if (!rst) begin
      done_edge = e + IC;
      kind      = 1;
      m_ready   = 1'b0;
      m_rdata   = 0;
      m_rknown  = 1'b1;
    end else if (e == done_edge) begin
      if (kind == 2) begin
        mem_m[p_idx]   = p_data;
        known_m[p_idx] = 1'b1;
      end else if (kind == 3) begin
        m_rdata  = mem_m[p_idx];
        m_rknown = known_m[p_idx];
        m_ready  = 1'b1;
      end
    end else if (e > done_edge && !i_cs) begin
      kind      = i_write ? 2 : 3;
      p_idx     = int'(i_bank) * (2 ** AB) + int'(i_address[AB-1:0]);
      p_data    = int'(i_dataToWrite);
      done_edge = e + (i_write ? WL : RL);
      m_ready   = 1'b0;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clkSys) begin
    if (chk_on) begin
      if (!rst) begin
        check("rst_busy", int'(o_busy), 1);
        check("rst_ready", int'(o_dataReady), 0);
        check("rst_rdata", int'(o_dataRead), 0);
        check("rst_state", int'(o_state), 1);
      end else begin
        exp_busy = (e < done_edge) ? 1 : 0;
        check("busy", int'(o_busy), exp_busy);
        check("state", int'(o_state), (exp_busy == 1) ? kind : 0);
        check("ready", int'(o_dataReady), int'(m_ready));
        if (m_rknown) check("rdata", int'(o_dataRead), m_rdata);
      end
    end
  end

  task automatic tick();
    @(posedge clkSys);
    #2;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (o_busy && n < 60) begin
      tick();
      n++;
    end
  endtask

  // Issue one request while idle; returns edges from acceptance until busy drops.
  task automatic req(input bit w, input logic [23:0] a, input bit bk,
                     input logic [7:0] d, output int lat);
    i_cs = 1'b0; i_write = w; i_address = a; i_bank = bk; i_dataToWrite = d;
    tick();
    check("accepted", int'(o_busy), 1);
    i_cs = 1'b1;
    i_write = 1'($urandom_range(1, 0));
    i_address = 24'($urandom);
    i_bank = 1'($urandom_range(1, 0));
    i_dataToWrite = 8'($urandom);
    wait_idle(lat);
  endtask

  initial begin
    int lat, n, last, cnt_r;
    bit prev;

    tick();
    chk_on = 1'b1;
    tick();
    tick();
    rst = 1'b1;
    wait_idle(n);
    check("init_len", n, IC);
    check("init_state", int'(o_state), 0);
    check("init_ready", int'(o_dataReady), 0);

    req(1'b1, 24'h001002, 1'b0, 8'hA5, lat);
    check("wr_lat", lat, WL);
    check("wr_ready", int'(o_dataReady), 0);
    req(1'b0, 24'h001002, 1'b0, 8'h00, lat);
    check("rd_lat", lat, RL);
    check("rd_ready", int'(o_dataReady), 1);
    check("rd_a5", int'(o_dataRead), 8'hA5);

    req(1'b1, 24'h000005, 1'b0, 8'h11, lat);
    req(1'b1, 24'h000005, 1'b1, 8'h22, lat);
    req(1'b0, 24'h000005, 1'b0, 8'h00, lat);
    check("bank0", int'(o_dataRead), 8'h11);
    req(1'b0, 24'h000005, 1'b1, 8'h00, lat);
    check("bank1", int'(o_dataRead), 8'h22);
    req(1'b0, 24'h000405, 1'b0, 8'h00, lat);
    check("alias", int'(o_dataRead), 8'h11);

    // Stray strobe two edges into a read must be dropped.
    i_cs = 1'b0; i_write = 1'b0; i_address = 24'h000005; i_bank = 1'b1;
    tick();
    i_cs = 1'b1;
    tick();
    i_cs = 1'b0; i_write = 1'b1; i_dataToWrite = 8'h77;
    tick();
    i_cs = 1'b1;
    wait_idle(n);
    check("ign_lat", n, RL - 2);
    check("ign_data", int'(o_dataRead), 8'h22);
    tick();
    tick();
    check("ign_idle", int'(o_busy), 0);
    check("ign_hold", int'(o_dataReady), 1);
    req(1'b0, 24'h000005, 1'b1, 8'h00, lat);
    check("ign_nowrite", int'(o_dataRead), 8'h22);

    // Reset in the middle of a write discards it.
    req(1'b1, 24'h000010, 1'b0, 8'h3C, lat);
    i_cs = 1'b0; i_write = 1'b1; i_address = 24'h000010; i_bank = 1'b0; i_dataToWrite = 8'hFF;
    tick();
    i_cs = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    wait_idle(n);
    check("init_len2", n, IC);
    req(1'b0, 24'h000010, 1'b0, 8'h00, lat);
    check("rst_discard", int'(o_dataRead), 8'h3C);
    req(1'b0, 24'h001002, 1'b0, 8'h00, lat);
    check("rst_keep", int'(o_dataRead), 8'hA5);

    // Strobe held low: back-to-back reads.
    i_cs = 1'b0; i_write = 1'b0; i_address = 24'h001002; i_bank = 1'b0;
    prev = o_dataReady;
    last = -1;
    cnt_r = 0;
    for (int k = 1; k <= 30; k++) begin
      tick();
      if (o_dataReady && !prev) begin
        if (last >= 0) check("b2b_gap", k - last, RL + 1);
        last = k;
        cnt_r++;
      end
      prev = o_dataReady;
    end
    check("b2b_count", cnt_r, 4);
    i_cs = 1'b1;
    wait_idle(n);

    for (int i = 0; i < 400; i++) begin
      i_cs = ($urandom_range(3, 0) == 0) ? 1'b1 : 1'b0;
      i_write = 1'($urandom_range(1, 0));
      i_bank = 1'($urandom_range(1, 0));
      i_address = {14'($urandom), 7'd0, 3'($urandom_range(7, 0))};
      i_dataToWrite = 8'($urandom);
      if ($urandom_range(99, 0) == 0) begin
        rst = 1'b0;
        tick();
        rst = 1'b1;
      end
      tick();
    end

    i_cs = 1'b1;
    repeat (30) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bram_mem_responder.md
BRAM_MEM_RESPONDER -- requirements
Module: bram_mem_responder

Interface
REQ-001 Parameter ADDR_BITS, default 10, meaning low address bits used per bank; depth is 2^(ADDR_BITS+1) bytes.
REQ-002 Parameter WR_LAT, default 4, meaning write latency in clkSys cycles, legal range >=1.
REQ-003 Parameter RD_LAT, default 6, meaning read latency in clkSys cycles, legal range >=1.
REQ-004 Parameter INIT_CYCLES, default 16, meaning post-reset busy period in cycles, legal range >=1.
REQ-005 Port clkSys  in  1  system clock, all state on rising edge.
REQ-006 Port rst  in  1  reset, asynchronous, active-low.
REQ-007 Port i_cs  in  1  request strobe, active-low, sampled on each rising edge.
REQ-008 Port i_write  in  1  1 = write, 0 = read.
REQ-009 Port i_address  in  24  byte address.
REQ-010 Port i_bank  in  1  bank select, forms the memory index MSB.
REQ-011 Port i_dataToWrite  in  8  write data.
REQ-012 Port o_dataRead  out  8  read data, registered.
REQ-013 Port o_busy  out  1  1 = request not accepted, registered.
REQ-014 Port o_dataReady  out  1  1 = o_dataRead holds the result of the last read, registered.
REQ-015 Port o_state  out  4  FSM state: 4'd0 IDLE, 4'd1 INIT, 4'd2 WRITE, 4'd3 READ; other codes unused.

Function
REQ-016 The block SHALL be a drop-in, memCtrl-client-compatible responder backed by internal on-chip RAM, for bring-up without PSRAM.
REQ-017 Memory index SHALL be {i_bank, i_address[ADDR_BITS-1:0]}; upper address bits are ignored, so addresses alias modulo 2^ADDR_BITS.
REQ-018 INIT: counter loaded with INIT_CYCLES; decrements each cycle; at terminal count -> IDLE, o_busy<=0 on the same edge.
REQ-019 IDLE: o_busy=0; i_cs=0 at edge N -> latch index, i_write and i_dataToWrite; o_busy<=1 and o_dataReady<=0 at edge N; next state WRITE or READ.
REQ-020 IDLE with i_cs=1 -> remain in IDLE, all outputs held.
REQ-021 WRITE: the latched byte SHALL be stored at edge N+WR_LAT, with state->IDLE and o_busy<=0 on that edge; o_dataReady stays 0.
REQ-022 READ: at edge N+RD_LAT, o_dataRead<=mem[index], o_dataReady<=1, o_busy<=0, state->IDLE.
REQ-023 o_dataReady and o_dataRead SHALL hold until the next accepted request or reset.
REQ-024 i_cs=0 while in INIT, WRITE or READ SHALL be ignored: no queuing, no latch update, no error.
REQ-025 Input changes during WRITE/READ SHALL not affect the transaction in flight.
REQ-026 i_cs held low continuously SHALL start a new transaction on every edge where state is IDLE, i.e. earliest re-accept at edge N+LAT+1.
REQ-027 A read from a location written by the immediately preceding transaction SHALL return the new value.
REQ-028 Memory contents SHALL not be initialised; reads of never-written locations return undefined data.

Reset
REQ-029 rst low SHALL asynchronously force state INIT, o_busy=1, o_dataReady=0, o_dataRead=8'h00, o_state=4'd1, and reload the init counter.
REQ-030 Reset during WRITE SHALL discard the pending write; the target location keeps its prior value.
REQ-031 Reset SHALL not clear memory contents; data written before reset remains readable after INIT completes.
REQ-032 After rst deasserts, the first request SHALL be accepted no earlier than INIT_CYCLES edges later.

Verification
REQ-033 Release rst -> o_busy=1, o_state=1 for 16 edges, then o_busy=0, o_state=0, o_dataReady=0.
REQ-034 Write 8'hA5 @ 24'h001002 bank0, then read same -> busy low 4 edges after write strobe; 6 edges after read strobe o_dataReady=1, o_dataRead=8'hA5.
REQ-035 Write 8'h11 @ 24'h000005 bank0, 8'h22 @ 24'h000005 bank1 -> reads return 8'h11 and 8'h22; read @ 24'h000405 bank0 (alias) -> 8'h11.
REQ-036 Extra i_cs=0 pulse 2 edges into a read; write with different data -> ignored, read result unchanged, no extra transaction.
REQ-037 Write 8'h3C @ 8'h10, then write 8'hFF @ 8'h10 with rst pulsed at edge N+2 -> after INIT, read returns 8'h3C.
REQ-038 i_cs held low, i_write=0 -> reads complete back-to-back, one per RD_LAT+1 edges, o_dataReady dropping for 1..RD_LAT cycles between results.
